// File: rtl/div_iter_if.sv
// Handshake and data bundle for the iterative divider.
// master: controller side (drives start/a/b); slave: divider side.
interface div_iter_if #(
  parameter int WIDTH = 32
);
  // start is sampled only while the divider is idle. busy covers the op
  // in flight. done is a one-cycle pulse, and q/r/div_zero are valid from
  // that cycle until the next completion. busy and done are never both high.
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [1:0]       dbg_state;

  modport master (
    output start, a, b,
    input  q, r, busy, done, div_zero, dbg_state
  );

  modport slave (
    input  start, a, b,
    output q, r, busy, done, div_zero, dbg_state
  );
endinterface

// File: rtl/div_iter.sv
// Iterative restoring divider: one quotient bit per cycle, WIDTH+2 cycles
// per operation (accept, WIDTH shift/subtract steps, sign fix-up).
// Optional macro DIV_SIGNED_EN: operands are two's complement, the quotient
// truncates toward zero and the remainder takes the sign of the dividend.
// Without the macro, operands are unsigned.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  div_iter_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] dvs_q, dvs_d;   // divisor magnitude
  logic [WIDTH-1:0] rem_q, rem_d;   // partial remainder, always < divisor
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   shifted;        // WIDTH+1 bits so the trial borrow is exact
  logic             ge;
  logic [WIDTH-1:0] q_fix, r_fix;

`ifdef DIV_SIGNED_EN
  logic sa_q, sa_d;
  logic sb_q, sb_d;
  // MIN negates to itself, which read unsigned is exactly 2^(WIDTH-1).
  assign a_mag = bus.a[WIDTH-1] ? (~bus.a + WIDTH'(1)) : bus.a;
  assign b_mag = bus.b[WIDTH-1] ? (~bus.b + WIDTH'(1)) : bus.b;
`else
  assign a_mag = bus.a;
  assign b_mag = bus.b;
`endif

  // One restoring step: bring in the next dividend bit and trial-subtract.
  assign shifted = {rem_q, dvd_q[WIDTH-1]};
  assign ge      = (shifted >= {1'b0, dvs_q});

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      zero_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
`ifdef DIV_SIGNED_EN
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      zero_q  <= zero_d;
      q_q     <= q_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
`ifdef DIV_SIGNED_EN
      sa_q    <= sa_d;
      sb_q    <= sb_d;
`endif
    end
  end

  // Next-state: accept in IDLE, WIDTH steps in CALC, one FIX cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_CALC;
      S_CALC:  if (cnt_q == LAST) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Result fix-up: divide-by-zero override, then sign correction.
  always_comb begin
    q_fix = dvd_q;
    r_fix = rem_q;
`ifdef DIV_SIGNED_EN
    if (sa_q ^ sb_q) q_fix = ~dvd_q + WIDTH'(1);
    if (sa_q)        r_fix = ~rem_q + WIDTH'(1);
`endif
    // With a zero divisor every step succeeds, so the remainder already
    // rebuilds the original dividend; only the quotient needs forcing.
    if (zero_q) q_fix = '1;
  end

  // Datapath and outputs per state.
  always_comb begin
    cnt_d  = cnt_q;
    dvd_d  = dvd_q;
    dvs_d  = dvs_q;
    rem_d  = rem_q;
    zero_d = zero_q;
    q_d    = q_q;
    r_d    = r_q;
    busy_d = busy_q;
    done_d = 1'b0;
    dz_d   = dz_q;
`ifdef DIV_SIGNED_EN
    sa_d   = sa_q;
    sb_d   = sb_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          dvd_d  = a_mag;
          dvs_d  = b_mag;
          rem_d  = '0;
          cnt_d  = '0;
          zero_d = (bus.b == '0);
          busy_d = 1'b1;
`ifdef DIV_SIGNED_EN
          sa_d   = bus.a[WIDTH-1];
          sb_d   = bus.b[WIDTH-1];
`endif
        end
      end
      S_CALC: begin
        rem_d = ge ? (shifted[WIDTH-1:0] - dvs_q) : shifted[WIDTH-1:0];
        dvd_d = {dvd_q[WIDTH-2:0], ge};
        cnt_d = cnt_q + CW'(1);
      end
      S_FIX: begin
        q_d    = q_fix;
        r_d    = r_fix;
        dz_d   = zero_q;
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign bus.q         = q_q;
  assign bus.r         = r_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.div_zero  = dz_q;
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter (WIDTH=32), default or DIV_SIGNED_EN build.
module tb_div_iter;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  div_iter_if #(.WIDTH(W)) bus ();
  div_iter #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  logic [2*W:0] exp_q[$];   // {div_zero, r, q}

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain arithmetic on wide integers.
  function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] q, r;
    longint sa, sb;
    if (b == '0) begin
      q = '1;
      r = a;
      return {1'b1, r, q};
    end
`ifdef DIV_SIGNED_EN
    sa = longint'($signed(a));
    sb = longint'($signed(b));
`else
    sa = longint'({32'd0, a});
    sb = longint'({32'd0, b});
`endif
    q = W'(sa / sb);
    r = W'(sa % sb);
    return {1'b0, r, q};
  endfunction

  // Scoreboard: every done pops one expected result.
  always @(negedge clk) begin : monitor
    logic [2*W:0] e;
    if (!reset && bus.done) begin
      check("busy_with_done", {63'd0, bus.busy}, 64'd0);
      if (exp_q.size() == 0) begin
        check("spurious_done", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("q", {32'd0, bus.q}, {32'd0, e[W-1:0]});
        check("r", {32'd0, bus.r}, {32'd0, e[2*W-1:W]});
        check("div_zero", {63'd0, bus.div_zero}, {63'd0, e[2*W]});
      end
    end
  end

  // Drive start for one edge; caller is #1 past an edge with the DUT idle.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1;
    bus.a = a;
    bus.b = b;
    @(posedge clk);
    exp_q.push_back(model(a, b));
    #1;
    bus.start = 1'b0;
  endtask

  // Edges after the start-sampling edge until done is seen (bounded).
  task automatic wait_done(output int n);
    n = 0;
    while (n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.done) return;
    end
    check("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    start_op(a, b);
    wait_done(n);
    check("latency", 64'(n), 64'(W + 1));
  endtask

  initial begin
    int n;
    int k;
    logic [W-1:0] ra, rb;
    logic [W-1:0] corners[4];
    corners[0] = 32'h8000_0000;
    corners[1] = 32'hFFFF_FFFF;
    corners[2] = 32'h0000_0001;
    corners[3] = 32'h7FFF_FFFF;

    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_q", {32'd0, bus.q}, 64'd0);
    check("rst_r", {32'd0, bus.r}, 64'd0);
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_done", {63'd0, bus.done}, 64'd0);
    check("rst_div_zero", {63'd0, bus.div_zero}, 64'd0);

    // Directed vectors.
    run_op(32'hFFFF_FFFF, 32'h0000_0010);
`ifndef DIV_SIGNED_EN
    check("tp_u_q", {32'd0, bus.q}, 64'h0FFF_FFFF);
    check("tp_u_r", {32'd0, bus.r}, 64'h0000_000F);
`else
    check("tp_m1_q", {32'd0, bus.q}, 64'h0);
    check("tp_m1_r", {32'd0, bus.r}, 64'hFFFF_FFFF);
`endif
    run_op(32'h1234_5678, 32'h0);
    check("tp_dz_q", {32'd0, bus.q}, 64'hFFFF_FFFF);
    check("tp_dz_r", {32'd0, bus.r}, 64'h1234_5678);
    check("tp_dz_flag", {63'd0, bus.div_zero}, 64'd1);
    run_op(32'h0000_0007, 32'hFFFF_FFFE);
    run_op(32'hFFFF_FFF9, 32'h0000_0002);
`ifdef DIV_SIGNED_EN
    check("tp_s_q", {32'd0, bus.q}, 64'hFFFF_FFFD);
    check("tp_s_r", {32'd0, bus.r}, 64'hFFFF_FFFF);
`endif
    run_op(32'h8000_0000, 32'hFFFF_FFFF);
`ifdef DIV_SIGNED_EN
    check("tp_ovf_q", {32'd0, bus.q}, 64'h8000_0000);
    check("tp_ovf_r", {32'd0, bus.r}, 64'h0);
`endif
    check("tp_ovf_dz", {63'd0, bus.div_zero}, 64'd0);

    // Starts while busy are ignored.
    start_op(32'd100, 32'd7);
    n = 0;
    while (n < 200) begin
      @(posedge clk);
      #1;
      n++;
      bus.start = 1'b0;
      if (bus.done) break;
      if (n == 5 || n == 20) begin
        bus.start = 1'b1;
        bus.a = 32'd1;
        bus.b = 32'd1;
      end
    end
    check("hs_latency", 64'(n), 64'(W + 1));
    check("hs_q", {32'd0, bus.q}, 64'd14);
    check("hs_r", {32'd0, bus.r}, 64'd2);
    // Start in the done cycle is accepted.
    start_op(32'd9, 32'd3);
    wait_done(n);
    check("b2b_latency", 64'(n), 64'(W + 1));
    check("b2b_q", {32'd0, bus.q}, 64'd3);
    check("b2b_r", {32'd0, bus.r}, 64'd0);

    // Reset mid-operation aborts without done.
    start_op(32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    check("abort_q", {32'd0, bus.q}, 64'd0);
    check("abort_r", {32'd0, bus.r}, 64'd0);
    check("abort_busy", {63'd0, bus.busy}, 64'd0);
    k = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done) k++;
    end
    check("abort_no_done", 64'(k), 64'd0);
    run_op(32'd50, 32'd5);
    check("post_rst_q", {32'd0, bus.q}, 64'd10);
    check("post_rst_r", {32'd0, bus.r}, 64'd0);

    // Random operations, some back-to-back, some with idle gaps.
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 4))
        0: ra = corners[$urandom_range(0, 3)];
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: rb = '0;
        1: rb = corners[$urandom_range(0, 3)];
        2: rb = W'($urandom_range(1, 255));
        3: rb = ~W'($urandom_range(0, 255));
        default: rb = $urandom;
      endcase
      run_op(ra, rb);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
